// File: rtl/fsm_sync_mc_if.sv
// fsm_sync_mc_if: per-channel RF detect inputs, controls and status outputs of the sync FSM block
interface fsm_sync_mc_if #(
  parameter int N_CH      = 4,
  parameter int TIMEOUT_W = 8
);
  logic [N_CH-1:0]      rfin;
  logic [N_CH-1:0]      sh_en;
  logic [N_CH-1:0]      fsm_rst;
  logic [TIMEOUT_W-1:0] timeout_cfg;
  logic                 flag_clr;
  logic [N_CH-1:0]      rfin_sync;
  logic [N_CH-1:0]      state;
  logic [N_CH-1:0]      start_pulse;
  logic [N_CH-1:0]      timeout_flag;
  logic                 any_active;
  modport master (
    output rfin, sh_en, fsm_rst, timeout_cfg, flag_clr,
    input  rfin_sync, state, start_pulse, timeout_flag, any_active
  );
  modport slave (
    input  rfin, sh_en, fsm_rst, timeout_cfg, flag_clr,
    output rfin_sync, state, start_pulse, timeout_flag, any_active
  );
endinterface

// File: rtl/fsm_sync_mc.sv
// fsm_sync_mc: multi-channel RF detect synchroniser with IDLE/ACTIVE/LOCKOUT window FSM and inactivity timeout
module fsm_sync_mc #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fsm_sync_mc_if.slave   bus
);
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ACTIVE  = 2'b01;
  localparam logic [1:0] LOCKOUT = 2'b10;
  localparam logic [TIMEOUT_W:0] ONE = {{TIMEOUT_W{1'b0}}, 1'b1};
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0]                  sh_en_prev_q, sh_en_prev_d;
  logic [N_CH-1:0]                  start_q, start_d;
  logic [N_CH-1:0]                  flag_q, flag_d;
  logic [N_CH-1:0][1:0]             st_q, st_d;
  logic [N_CH-1:0][TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]                  rfin_sync, sh_fall, act;
  logic [TIMEOUT_W:0]               inc;
  logic                             hit;
  assign sync_d       = {sync_q[SYNC_STAGES-2:0], bus.rfin};
  assign rfin_sync    = sync_q[SYNC_STAGES-1];
  assign sh_en_prev_d = bus.sh_en;
  assign sh_fall      = sh_en_prev_q & ~bus.sh_en;
  for (genvar c = 0; c < N_CH; c++) begin : g_act
    assign act[c] = st_q[c] == ACTIVE;
  end
  assign bus.rfin_sync    = rfin_sync;
  assign bus.state        = act;
  assign bus.start_pulse  = start_q;
  assign bus.timeout_flag = flag_q;
  assign bus.any_active   = |act;
  // next state per channel; the counter measures quiet ACTIVE cycles and the extra msb of inc catches saturation
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    start_d = '0;
    flag_d  = flag_q & ~{N_CH{bus.flag_clr}};
    inc     = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      inc = {1'b0, cnt_q[i]} + ONE;
      hit = (bus.timeout_cfg != '0) && (inc >= {1'b0, bus.timeout_cfg});
      if (st_q[i] == IDLE) begin
        st_d[i]    = (!bus.fsm_rst[i] && rfin_sync[i]) ? ACTIVE : IDLE;
        start_d[i] = !bus.fsm_rst[i] && rfin_sync[i];
      end else if (st_q[i] == ACTIVE) begin
        st_d[i]   = bus.fsm_rst[i] ? IDLE : (sh_fall[i] || hit) ? LOCKOUT : ACTIVE;
        flag_d[i] = flag_d[i] | (!bus.fsm_rst[i] && !sh_fall[i] && hit);
      end else begin
        st_d[i] = (bus.fsm_rst[i] || !rfin_sync[i]) ? IDLE : LOCKOUT;
      end
      cnt_d[i] = (st_q[i] != ACTIVE || bus.sh_en[i]) ? '0 : inc[TIMEOUT_W] ? cnt_q[i] : inc[TIMEOUT_W-1:0];
    end
  end
  // all state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      sh_en_prev_q <= '0;
      start_q      <= '0;
      flag_q       <= '0;
      st_q         <= '0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= sync_d;
      sh_en_prev_q <= sh_en_prev_d;
      start_q      <= start_d;
      flag_q       <= flag_d;
      st_q         <= st_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fsm_sync_mc.sv
// tb_fsm_sync_mc: directed and random stimulus against a cycle-level reference model of the sync FSM block
`timescale 1ns/100ps
module tb_fsm_sync_mc;
  localparam int N = 4;
  localparam int S = 2;
  localparam int TW = 8;
  localparam int M_IDLE = 0;
  localparam int M_ACT = 1;
  localparam int M_LOCK = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fsm_sync_mc_if #(.N_CH(N), .TIMEOUT_W(TW)) bus ();
  fsm_sync_mc #(.N_CH(N), .SYNC_STAGES(S), .TIMEOUT_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [N-1:0] hist[$];
  int mode[N];
  int quiet[N];
  logic [N-1:0] m_sp, m_flag, m_shprev;
  logic [TW-1:0] cfgs[5] = '{8'd0, 8'd1, 8'd3, 8'd10, 8'd40};
  int n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_rs();
    return hist.size() == S ? hist[0] : '0;
  endfunction

  function automatic logic [N-1:0] m_state();
    logic [N-1:0] st;
    st = '0;
    for (int i = 0; i < N; i++) st[i] = mode[i] == M_ACT;
    return st;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < N; i++) begin
      mode[i] = M_IDLE;
      quiet[i] = 0;
    end
    m_sp = '0;
    m_flag = '0;
    m_shprev = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] rs, fall;
    rs = m_rs();
    fall = m_shprev & ~bus.sh_en;
    m_flag &= ~{N{bus.flag_clr}};
    m_sp = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[i])
        M_IDLE: if (!bus.fsm_rst[i] && rs[i]) begin
          mode[i] = M_ACT;
          quiet[i] = 0;
          m_sp[i] = 1'b1;
        end
        M_ACT: if (bus.fsm_rst[i]) mode[i] = M_IDLE;
          else if (fall[i]) mode[i] = M_LOCK;
          else if (bus.timeout_cfg != 0 && quiet[i] + 1 >= int'(bus.timeout_cfg)) begin
            mode[i] = M_LOCK;
            m_flag[i] = 1'b1;
          end else quiet[i] = bus.sh_en[i] ? 0 : quiet[i] + 1;
        default: if (bus.fsm_rst[i] || !rs[i]) mode[i] = M_IDLE;
      endcase
    end
    m_shprev = bus.sh_en;
    hist.push_back(bus.rfin);
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  task automatic check_outputs();
    check("rfin_sync", 32'(bus.rfin_sync), 32'(m_rs()));
    check("state", 32'(bus.state), 32'(m_state()));
    check("start_pulse", 32'(bus.start_pulse), 32'(m_sp));
    check("timeout_flag", 32'(bus.timeout_flag), 32'(m_flag));
    check("any_active", 32'(bus.any_active), 32'(|m_state()));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1 check_outputs();
  endtask

  initial begin
    bus.rfin = '0;
    bus.sh_en = '0;
    bus.fsm_rst = '0;
    bus.timeout_cfg = '0;
    bus.flag_clr = 1'b0;
    model_reset();
    repeat (2) cyc();
    check("reset_state", 32'(bus.state), 32'h0);
    rst_n = 1'b1;
    bus.rfin[0] = 1'b1;
    cyc();
    cyc();
    check("t1_sync", 32'(bus.rfin_sync[0]), 32'h1);
    check("t1_not_yet", 32'(bus.state[0]), 32'h0);
    cyc();
    check("t1_state", 32'(bus.state), 32'h1);
    check("t1_pulse", 32'(bus.start_pulse), 32'h1);
    check("t1_any", 32'(bus.any_active), 32'h1);
    cyc();
    check("t1_pulse_end", 32'(bus.start_pulse[0]), 32'h0);
    bus.rfin[1] = 1'b1;
    repeat (3) cyc();
    check("t2_active", 32'(bus.state[1]), 32'h1);
    bus.sh_en[1] = 1'b1;
    repeat (5) cyc();
    bus.sh_en[1] = 1'b0;
    cyc();
    check("t2_fall_exit", 32'(bus.state[1]), 32'h0);
    repeat (4) cyc();
    check("t2_lockout", 32'(bus.state[1]), 32'h0);
    bus.rfin[1] = 1'b0;
    repeat (3) cyc();
    bus.rfin[1] = 1'b1;
    repeat (3) cyc();
    check("t2_rearm_pulse", 32'(bus.start_pulse[1]), 32'h1);
    bus.timeout_cfg = 8'd10;
    bus.rfin[2] = 1'b1;
    n = 0;
    while (!bus.state[2] && n < 10) begin
      cyc();
      n++;
    end
    check("t3_entry", 32'(bus.state[2]), 32'h1);
    n = 0;
    while (bus.state[2] && n < 20) begin
      cyc();
      n++;
    end
    check("t3_timeout_len", 32'(n), 32'd10);
    check("t3_flag", 32'(bus.timeout_flag[2]), 32'h1);
    repeat (3) cyc();
    check("t3_flag_sticky", 32'(bus.timeout_flag[2]), 32'h1);
    bus.flag_clr = 1'b1;
    cyc();
    bus.flag_clr = 1'b0;
    check("t3_flag_clr", 32'(bus.timeout_flag[2]), 32'h0);
    bus.timeout_cfg = 8'd0;
    bus.rfin[2] = 1'b0;
    repeat (3) cyc();
    bus.rfin[2] = 1'b1;
    repeat (3) cyc();
    check("t3_rearm", 32'(bus.state[2]), 32'h1);
    repeat (300) cyc();
    check("t3_no_timeout", 32'(bus.state[2]), 32'h1);
    bus.rfin[3] = 1'b1;
    repeat (3) cyc();
    check("t4_active", 32'(bus.state[3]), 32'h1);
    bus.sh_en[3] = 1'b1;
    cyc();
    bus.sh_en[3] = 1'b0;
    bus.fsm_rst[3] = 1'b1;
    cyc();
    check("t4_rst_fall", 32'(bus.state[3]), 32'h0);
    bus.fsm_rst[3] = 1'b0;
    cyc();
    check("t4_reenter", 32'(bus.state[3]), 32'h1);
    check("t4_reenter_pulse", 32'(bus.start_pulse[3]), 32'h1);
    bus.rfin = '1;
    bus.fsm_rst = '1;
    cyc();
    bus.fsm_rst = '0;
    cyc();
    check("t5_all_active", 32'(bus.state), 32'hf);
    #2 rst_n = 1'b0;
    #0.5;
    check("t5_async_state", 32'(bus.state), 32'h0);
    check("t5_async_sync", 32'(bus.rfin_sync), 32'h0);
    check("t5_async_any", 32'(bus.any_active), 32'h0);
    check("t5_async_flag", 32'(bus.timeout_flag), 32'h0);
    model_reset();
    #0.5 rst_n = 1'b1;
    repeat (2) cyc();
    check("t5_rearm_early", 32'(bus.state), 32'h0);
    cyc();
    check("t5_rearm", 32'(bus.state), 32'hf);
    bus.timeout_cfg = 8'd6;
    bus.flag_clr = 1'b1;
    n = 0;
    while (bus.state[0] && n < 20) begin
      cyc();
      n++;
    end
    check("t6_len", 32'(n), 32'd6);
    check("t6_set_wins", 32'(bus.timeout_flag), 32'hf);
    bus.timeout_cfg = 8'd50;
    bus.fsm_rst = '1;
    cyc();
    bus.fsm_rst = '0;
    bus.flag_clr = 1'b0;
    check("t7_flag_cleared", 32'(bus.timeout_flag), 32'h0);
    cyc();
    repeat (20) cyc();
    check("t7_still_active", 32'(bus.state[0]), 32'h1);
    bus.timeout_cfg = 8'd5;
    cyc();
    check("t7_cfg_lower", 32'(bus.state[0]), 32'h0);
    check("t7_cfg_lower_flag", 32'(bus.timeout_flag[0]), 32'h1);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) bus.rfin[i] = ~bus.rfin[i];
        if ($urandom_range(5) == 0) bus.sh_en[i] = ~bus.sh_en[i];
        bus.fsm_rst[i] = $urandom_range(29) == 0;
      end
      bus.flag_clr = $urandom_range(15) == 0;
      if ($urandom_range(99) == 0) bus.timeout_cfg = cfgs[$urandom_range(4)];
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
